// File: rtl/lsq_drain_unit_pkg.sv
// lsq_pkg: LSQ entry layout, access-size codes, drain FSM states and entry unpack helper
package lsq_pkg;
  localparam int ENTRY_WIDTH = 81;
  localparam int ROB_TAG_W = 6;
  localparam int PRD_W = 7;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;
  localparam int ADDR_LSB = 0;
  localparam int SDATA_LSB = 32;
  localparam int PRD_LSB = 64;
  localparam int TAG_LSB = 71;
  localparam int SIZE_LSB = 77;
  localparam int SEXT_BIT = 79;
  localparam int STORE_BIT = 80;
  localparam logic [SIZE_W-1:0] SZ_B = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_H = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_W = 2'b10;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_RESP, WB, DRAIN} state_t;
  typedef struct packed {
    logic                 is_store;
    logic                 sext;
    logic [SIZE_W-1:0]    size;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PRD_W-1:0]     prd;
    logic [DATA_W-1:0]    sdata;
    logic [DATA_W-1:0]    addr;
  } entry_t;
  function automatic entry_t to_entry(input logic [ENTRY_WIDTH-1:0] d);
    return '{is_store: d[STORE_BIT], sext: d[SEXT_BIT], size: d[SIZE_LSB +: SIZE_W],
             rob_tag: d[TAG_LSB +: ROB_TAG_W], prd: d[PRD_LSB +: PRD_W],
             sdata: d[SDATA_LSB +: DATA_W], addr: d[ADDR_LSB +: DATA_W]};
  endfunction
endpackage

// File: rtl/lsq_drain_unit_if.sv
// lsq_drain_unit_if: queue head, dcache and writeback signals; master = drain unit, slave = queue/cache/ROB side
interface lsq_drain_unit_if;
  import lsq_pkg::*;
  logic                   flush_i;
  logic                   valid_i;
  logic [ENTRY_WIDTH-1:0] data_i;
  logic                   ready_o;
  logic                   dc_req_valid_o;
  logic                   dc_req_ready_i;
  logic                   dc_req_we_o;
  logic [31:0]            dc_req_addr_o;
  logic [31:0]            dc_req_wdata_o;
  logic [3:0]             dc_req_be_o;
  logic                   dc_resp_valid_i;
  logic [31:0]            dc_resp_rdata_i;
  logic                   wb_valid_o;
  logic                   wb_is_store_o;
  logic                   wb_exc_o;
  logic [ROB_TAG_W-1:0]   wb_rob_tag_o;
  logic [PRD_W-1:0]       wb_prd_o;
  logic [31:0]            wb_data_o;
  modport master (
    input  flush_i, valid_i, data_i, dc_req_ready_i, dc_resp_valid_i, dc_resp_rdata_i,
    output ready_o, dc_req_valid_o, dc_req_we_o, dc_req_addr_o, dc_req_wdata_o, dc_req_be_o,
           wb_valid_o, wb_is_store_o, wb_exc_o, wb_rob_tag_o, wb_prd_o, wb_data_o
  );
  modport slave (
    output flush_i, valid_i, data_i, dc_req_ready_i, dc_resp_valid_i, dc_resp_rdata_i,
    input  ready_o, dc_req_valid_o, dc_req_we_o, dc_req_addr_o, dc_req_wdata_o, dc_req_be_o,
           wb_valid_o, wb_is_store_o, wb_exc_o, wb_rob_tag_o, wb_prd_o, wb_data_o
  );
endinterface

// File: rtl/lsq_drain_unit_align.sv
// lsu_align: in off/size/sext/sdata/rdata, out be/wdata (store lane steering), ldata (shifted+extended load), misalign
module lsu_align
  import lsq_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {off, 3'b000};
    be = size == SZ_B ? 4'b0001 << off : size == SZ_H ? 4'b0011 << off : 4'b1111;
    wdata = size == SZ_B ? {4{sdata[7:0]}} : size == SZ_H ? {2{sdata[15:0]}} : sdata;
    ldata = size == SZ_B ? {{24{sext & sh[7]}}, sh[7:0]} :
            size == SZ_H ? {{16{sext & sh[15]}}, sh[15:0]} : sh;
    misalign = ((size == SZ_H) & off[0]) | ((size == SZ_W) & (|off)) | (size == 2'b11);
  end
endmodule

// File: rtl/lsq_drain_unit.sv
// lsq_drain_unit: pops LSQ head, issues one dcache access per entry, writes back result; ports clk, rst (sync active-low), bus (master)
module lsq_drain_unit
  import lsq_pkg::*;
(
  input logic              clk,
  input logic              rst,
  lsq_drain_unit_if.master bus
);
  state_t      state;
  entry_t      ent, in_e;
  logic [31:0] res, ldata, wdata;
  logic [3:0]  be;
  logic        exc, wbv, mis, idle, req, pop;
  assign in_e = to_entry(bus.data_i);
  assign idle = state == IDLE;
  assign req = state == REQ;
  assign pop = bus.valid_i & bus.ready_o;
  lsu_align u_align (
    .off(idle ? in_e.addr[1:0] : ent.addr[1:0]),
    .size(idle ? in_e.size : ent.size),
    .sext(idle ? in_e.sext : ent.sext),
    .sdata(ent.sdata),
    .rdata(bus.dc_resp_rdata_i),
    .be(be),
    .wdata(wdata),
    .ldata(ldata),
    .misalign(mis)
  );
  assign bus.ready_o = idle & ~bus.flush_i;
  assign bus.dc_req_valid_o = req;
  assign bus.dc_req_we_o = req & ent.is_store;
  assign bus.dc_req_addr_o = req ? {ent.addr[31:2], 2'b00} : '0;
  assign bus.dc_req_wdata_o = req ? wdata : '0;
  assign bus.dc_req_be_o = req ? be : '0;
  assign bus.wb_valid_o = wbv & ~bus.flush_i;
  assign bus.wb_is_store_o = bus.wb_valid_o & ent.is_store;
  assign bus.wb_exc_o = bus.wb_valid_o & exc;
  assign bus.wb_rob_tag_o = bus.wb_valid_o ? ent.rob_tag : '0;
  assign bus.wb_prd_o = bus.wb_valid_o ? ent.prd : '0;
  assign bus.wb_data_o = bus.wb_valid_o ? res : '0;
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      ent <= '0;
      res <= '0;
      exc <= 1'b0;
      wbv <= 1'b0;
    end else begin
      wbv <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          ent <= in_e;
          res <= '0;
          exc <= mis;
          wbv <= mis;
          state <= mis ? WB : REQ;
        end
        REQ: if (bus.dc_req_ready_i) begin
          wbv <= ent.is_store & ~bus.flush_i;
          state <= bus.flush_i ? (ent.is_store ? IDLE : DRAIN) : (ent.is_store ? WB : WAIT_RESP);
        end else if (bus.flush_i) state <= IDLE;
        WAIT_RESP: if (bus.dc_resp_valid_i) begin
          res <= ldata;
          wbv <= ~bus.flush_i;
          state <= bus.flush_i ? IDLE : WB;
        end else if (bus.flush_i) state <= DRAIN;
        WB: state <= IDLE;
        DRAIN: if (bus.dc_resp_valid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
